// File: rtl/channel_accumulator_if.sv
// Pixel streams around the channel accumulator.
//   pixel_in/pixel_valid/pixel_ready : 20-bit convolution results flowing in
//   pixel_out/out_valid/out_ready    : 8-bit requantised pixels flowing out
// master = producer/consumer side (the environment), slave = the accumulator.
interface channel_accumulator_if;
  logic [19:0] pixel_in;
  logic        pixel_valid;
  logic        pixel_ready;
  logic [7:0]  pixel_out;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output pixel_in, pixel_valid, out_ready,
    input  pixel_ready, pixel_out, out_valid
  );

  modport slave (
    input  pixel_in, pixel_valid, out_ready,
    output pixel_ready, pixel_out, out_valid
  );
endinterface

// File: rtl/channel_accumulator.sv
// Sums per-channel convolution results across all input channels into a
// partial-sum frame buffer. On the last channel pass each sum is rounded,
// right-shifted, saturated to 8 bits and streamed out through a 2-deep FIFO.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   start         : one-cycle layer start (ignored while busy)
//   num_channels  : channel passes per layer (0 behaves as 1)
//   stage_width   : active columns, stage_height : active rows
//   shift         : requantisation right shift
//   bus           : input and output pixel streams (slave modport)
//   busy          : layer in progress, done : one-cycle end-of-layer pulse
module channel_accumulator #(
  parameter int unsigned IMAGE_WIDTH  = 128,
  parameter int unsigned IMAGE_HEIGHT = 128,
  parameter int unsigned ACC_WIDTH    = 28
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [7:0]                  num_channels,
  input  logic [7:0]                  stage_width,
  input  logic [7:0]                  stage_height,
  input  logic [4:0]                  shift,
  channel_accumulator_if.slave        bus,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned Depth = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int unsigned AddrW = $clog2(Depth);

  typedef enum logic [1:0] {StIdle, StAccum, StFinal, StDrain} state_e;

  state_e state_q, state_d;

  // Layer configuration, held for the whole layer
  logic [7:0] width_q, height_q, nch_q;
  logic [4:0] shift_q;

  // Raster position
  logic [7:0]       col_q, row_q, pass_q;
  logic [AddrW-1:0] addr_q;

  // Stage-1 pipeline registers (pixel accepted on the previous edge)
  logic                 s1_valid_q, s1_first_q, s1_final_q;
  logic [19:0]          s1_pixel_q;
  logic [AddrW-1:0]     s1_addr_q;
  logic [ACC_WIDTH-1:0] rd_data_q;

  logic [ACC_WIDTH-1:0] mem [Depth];

  // Output FIFO
  logic [7:0] fifo_q [2];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] fifo_cnt_q;

  logic                 ready, accept, push, pop, load_cfg;
  logic                 last_pix;
  logic [2:0]           occ;
  logic [ACC_WIDTH-1:0] sum;
  logic [ACC_WIDTH:0]   rnd, rounded;
  logic [7:0]           qpix;

  assign push     = s1_valid_q && s1_final_q;
  assign pop      = bus.out_valid && bus.out_ready;
  assign last_pix = (col_q == width_q - 8'd1) && (row_q == height_q - 8'd1);

  // Occupancy the FIFO will have after this edge, counting the in-flight
  // write and a pop happening now; a new accept pushes one edge later.
  assign occ = {1'b0, fifo_cnt_q} + {2'b00, push} - {2'b00, pop};

  always_comb begin
    ready = 1'b0;
    unique case (state_q)
      StAccum: ready = 1'b1;
      StFinal: ready = (occ < 3'd2);
      default: ready = 1'b0;
    endcase
  end

  assign bus.pixel_ready = ready;
  assign accept          = bus.pixel_valid && ready;
  assign busy            = (state_q != StIdle);

  always_comb begin
    state_d  = state_q;
    done     = 1'b0;
    load_cfg = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          load_cfg = 1'b1;
          state_d  = (num_channels > 8'd1) ? StAccum : StFinal;
        end
      end
      StAccum: begin
        if (accept && last_pix && (pass_q == nch_q - 8'd2)) state_d = StFinal;
      end
      StFinal: begin
        if (accept && last_pix) state_d = StDrain;
      end
      StDrain: begin
        if ((fifo_cnt_q == 2'd0) && !s1_valid_q) begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      width_q  <= '0;
      height_q <= '0;
      nch_q    <= '0;
      shift_q  <= '0;
      col_q    <= '0;
      row_q    <= '0;
      pass_q   <= '0;
      addr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load_cfg) begin
        width_q  <= stage_width;
        height_q <= stage_height;
        nch_q    <= (num_channels == 8'd0) ? 8'd1 : num_channels;
        shift_q  <= shift;
        col_q    <= '0;
        row_q    <= '0;
        pass_q   <= '0;
        addr_q   <= '0;
      end else if (accept) begin
        if (col_q == width_q - 8'd1) begin
          col_q <= '0;
          if (row_q == height_q - 8'd1) begin
            row_q  <= '0;
            addr_q <= '0;
            pass_q <= pass_q + 8'd1;
          end else begin
            row_q  <= row_q + 8'd1;
            addr_q <= addr_q + AddrW'(1);
          end
        end else begin
          col_q  <= col_q + 8'd1;
          addr_q <= addr_q + AddrW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_final_q <= 1'b0;
      s1_pixel_q <= '0;
      s1_addr_q  <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_pixel_q <= bus.pixel_in;
        s1_addr_q  <= addr_q;
        s1_first_q <= (pass_q == 8'd0);
        s1_final_q <= (state_q == StFinal);
      end
    end
  end

  // Frame buffer: no reset, pass 0 ignores stale contents
  always_ff @(posedge clk) begin
    if (accept) rd_data_q <= mem[addr_q];
    if (s1_valid_q && !s1_final_q) mem[s1_addr_q] <= sum;
  end

  always_comb begin
    sum     = (s1_first_q ? '0 : rd_data_q) + ACC_WIDTH'(s1_pixel_q);
    rnd     = (shift_q != 5'd0) ? ((ACC_WIDTH + 1)'(1) << (shift_q - 5'd1)) : '0;
    rounded = ({1'b0, sum} + rnd) >> shift_q;
    qpix    = (rounded > (ACC_WIDTH + 1)'(255)) ? 8'hff : rounded[7:0];
  end

  // Never pushed while full: ready already reserves a slot for each accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= qpix;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign bus.out_valid = (fifo_cnt_q != 2'd0);
  assign bus.pixel_out = fifo_q[rd_ptr_q];

endmodule

// File: tb/tb_channel_accumulator.sv
module tb_channel_accumulator;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] num_channels = '0, stage_width = '0, stage_height = '0;
  logic [4:0] shift = '0;
  logic       busy, done;

  channel_accumulator_if bus ();

  channel_accumulator dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_channels (num_channels),
    .stage_width  (stage_width),
    .stage_height (stage_height),
    .shift        (shift),
    .bus          (bus),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  int src[$];
  int got[$];
  int done_cnt, first_acc, first_ov, notready_cnt, acc_at_stall, ready_at_stall, stall_moves;
  int stall_cycles = 0;
  int busy_start_cycle = -1;

  task automatic start_layer(input int w, input int h, input int nch, input int sh);
    stage_width  = 8'(w);
    stage_height = 8'(h);
    num_channels = 8'(nch);
    shift        = 5'(sh);
    start        = 1'b1;
    @(posedge clk); #1;
    start        = 1'b0;
    // scramble configuration: the layer must run on the sampled copy
    stage_width  = 8'd0;
    stage_height = 8'd0;
    num_channels = 8'd7;
    shift        = 5'd31;
  endtask

  // Feeds src in order and records every popped output into got.
  task automatic run_stream(input int max_cycles, output bit timed_out);
    int  idx = 0;
    int  prev_out = 0;
    bit  prev_valid = 0;
    bit  saw_done;
    got.delete();
    done_cnt = 0; first_acc = -1; first_ov = -1; notready_cnt = 0;
    acc_at_stall = -1; ready_at_stall = -1; stall_moves = 0;
    timed_out = 1'b1;
    for (int c = 0; c < max_cycles; c++) begin
      bus.pixel_valid = (idx < src.size());
      bus.pixel_in    = (idx < src.size()) ? 20'(src[idx]) : 20'd0;
      bus.out_ready   = (c >= stall_cycles);
      start           = (c == busy_start_cycle);
      @(negedge clk);
      saw_done = done;
      if (bus.pixel_valid && bus.pixel_ready) begin
        if (first_acc < 0) first_acc = c;
        idx++;
      end
      if (bus.pixel_valid && !bus.pixel_ready) notready_cnt++;
      if (c < stall_cycles && bus.out_valid && prev_valid && (int'(bus.pixel_out) != prev_out))
        stall_moves++;
      prev_valid = bus.out_valid;
      prev_out   = int'(bus.pixel_out);
      if (c == stall_cycles - 1) begin
        acc_at_stall   = idx;
        ready_at_stall = int'(bus.pixel_ready);
      end
      if (bus.out_valid && first_ov < 0) first_ov = c;
      if (bus.out_valid && bus.out_ready) got.push_back(int'(bus.pixel_out));
      if (saw_done) done_cnt++;
      @(posedge clk); #1;
      if (saw_done) begin
        timed_out = 1'b0;
        break;
      end
    end
    bus.pixel_valid = 1'b0;
    bus.out_ready   = 1'b1;
    start           = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    vectors++; if (bus.pixel_ready !== 1'b0) begin errors++; $display("FAIL reset_pixel_ready got %b want 0", bus.pixel_ready); end
    vectors++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    vectors++; if (bus.pixel_out !== 8'd0) begin errors++; $display("FAIL reset_pixel_out got %0d want 0", bus.pixel_out); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_pass();
    bit to;
    src.delete();
    for (int i = 0; i < 16; i++) src.push_back(i);
    start_layer(4, 4, 1, 0);
    run_stream(200, to);
    vectors++; if (to) begin errors++; $display("FAIL single_timeout got timeout want done"); end
    vectors++; if (got.size() != 16) begin errors++; $display("FAIL single_count got %0d want 16", got.size()); end
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if ((i < got.size() ? got[i] : -1) != i) begin
        errors++; $display("FAIL single_data[%0d] got %0d want %0d", i, (i < got.size() ? got[i] : -1), i);
      end
    end
    vectors++; if (first_ov - first_acc != 2) begin errors++; $display("FAIL single_latency got %0d want 2", first_ov - first_acc); end
    vectors++; if (done_cnt != 1) begin errors++; $display("FAIL single_done got %0d want 1", done_cnt); end
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL single_idle got busy=%b done=%b want 0 0", busy, done); end
    @(posedge clk); #1;
  endtask

  task automatic test_multi_pass();
    bit to;
    src.delete();
    for (int i = 0; i < 12; i++) src.push_back(10);
    start_layer(2, 2, 3, 2);
    run_stream(200, to);
    vectors++; if (to || done_cnt != 1) begin errors++; $display("FAIL multi_done got to=%0d done=%0d want 0 1", to, done_cnt); end
    vectors++; if (notready_cnt != 0) begin errors++; $display("FAIL multi_ready got %0d stalls want 0", notready_cnt); end
    vectors++; if (got.size() != 4) begin errors++; $display("FAIL multi_count got %0d want 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ((i < got.size() ? got[i] : -1) != 8) begin
        errors++; $display("FAIL multi_data[%0d] got %0d want 8", i, (i < got.size() ? got[i] : -1));
      end
    end
  endtask

  task automatic test_saturate();
    bit to;
    src.delete();
    for (int i = 0; i < 8; i++) src.push_back(200);
    start_layer(2, 2, 2, 0);
    run_stream(200, to);
    vectors++; if (to || got.size() != 4) begin errors++; $display("FAIL sat_count got %0d want 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ((i < got.size() ? got[i] : -1) != 255) begin
        errors++; $display("FAIL sat_data[%0d] got %0d want 255", i, (i < got.size() ? got[i] : -1));
      end
    end
    src.delete();
    for (int i = 0; i < 8; i++) src.push_back(1000);
    start_layer(2, 2, 2, 4);
    run_stream(200, to);
    vectors++; if (to || got.size() != 4) begin errors++; $display("FAIL shift_count got %0d want 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ((i < got.size() ? got[i] : -1) != 125) begin
        errors++; $display("FAIL shift_data[%0d] got %0d want 125", i, (i < got.size() ? got[i] : -1));
      end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    src = '{1, 2, 3, 4};
    stall_cycles = 10;
    start_layer(2, 2, 1, 0);
    run_stream(200, to);
    stall_cycles = 0;
    vectors++; if (acc_at_stall != 2) begin errors++; $display("FAIL bp_accepted got %0d want 2", acc_at_stall); end
    vectors++; if (ready_at_stall != 0) begin errors++; $display("FAIL bp_ready got %0d want 0", ready_at_stall); end
    vectors++; if (stall_moves != 0) begin errors++; $display("FAIL bp_stable got %0d changes want 0", stall_moves); end
    vectors++; if (to || got.size() != 4) begin errors++; $display("FAIL bp_count got %0d want 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ((i < got.size() ? got[i] : -1) != i + 1) begin
        errors++; $display("FAIL bp_data[%0d] got %0d want %0d", i, (i < got.size() ? got[i] : -1), i + 1);
      end
    end
  endtask

  task automatic test_reset_abort();
    bit to;
    src.delete();
    for (int i = 0; i < 12; i++) src.push_back(5);
    start_layer(2, 2, 3, 0);
    run_stream(6, to);
    vectors++; if (!to || done_cnt != 0) begin errors++; $display("FAIL abort_early_done got %0d want 0", done_cnt); end
    rst = 1'b1;
    #1;
    vectors++; if (bus.pixel_ready !== 1'b0) begin errors++; $display("FAIL abort_pixel_ready got %b want 0", bus.pixel_ready); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    vectors++; if (bus.out_valid !== 1'b0 || bus.pixel_out !== 8'd0) begin errors++; $display("FAIL abort_out got v=%b d=%0d want 0 0", bus.out_valid, bus.pixel_out); end
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_after got done=%b busy=%b want 0 0", done, busy); end
    @(posedge clk); #1;
    src = '{7, 9};
    start_layer(2, 1, 1, 0);
    run_stream(100, to);
    vectors++; if (to || got.size() != 2) begin errors++; $display("FAIL abort_new_count got %0d want 2", got.size()); end
    vectors++; if (got.size() != 2 || got[0] != 7 || got[1] != 9) begin errors++; $display("FAIL abort_new_data got %p want 7 9", got); end
  endtask

  task automatic test_start_busy();
    bit to;
    src = '{5, 6, 7, 8};
    busy_start_cycle = 2;
    start_layer(2, 2, 1, 0);
    run_stream(100, to);
    busy_start_cycle = -1;
    vectors++; if (to || done_cnt != 1) begin errors++; $display("FAIL busy_start_done got to=%0d done=%0d want 0 1", to, done_cnt); end
    vectors++; if (got.size() != 4) begin errors++; $display("FAIL busy_start_count got %0d want 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ((i < got.size() ? got[i] : -1) != i + 5) begin
        errors++; $display("FAIL busy_start_data[%0d] got %0d want %0d", i, (i < got.size() ? got[i] : -1), i + 5);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle got %b want 0", busy); end
  endtask

  task automatic test_zero_channels();
    bit to;
    int exp[4] = '{2, 2, 3, 3};
    src = '{3, 4, 5, 6};
    start_layer(2, 2, 0, 1);
    run_stream(100, to);
    vectors++; if (to || done_cnt != 1) begin errors++; $display("FAIL zero_ch_done got to=%0d done=%0d want 0 1", to, done_cnt); end
    vectors++; if (got.size() != 4) begin errors++; $display("FAIL zero_ch_count got %0d want 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ((i < got.size() ? got[i] : -1) != exp[i]) begin
        errors++; $display("FAIL zero_ch_data[%0d] got %0d want %0d", i, (i < got.size() ? got[i] : -1), exp[i]);
      end
    end
  endtask

  initial begin
    bus.pixel_in    = '0;
    bus.pixel_valid = 1'b0;
    bus.out_ready   = 1'b1;
    test_reset();
    test_single_pass();
    test_multi_pass();
    test_saturate();
    test_backpressure();
    test_reset_abort();
    test_start_busy();
    test_zero_channels();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/channel_accumulator.md
Name: channel_accumulator

Overview:
- Sits directly downstream of the 3x3 convolution stage.
- Consumes the 20-bit unsigned per-channel convolution results and sums them across all input channels into a partial-sum frame buffer.
- On the last channel pass, rescales each sum by an arithmetic right shift with rounding, saturates it to 8 bits, and streams it to the next layer's line collector through a valid/ready interface.

Parameters:
- IMAGE_WIDTH, 128, max columns per stage
- IMAGE_HEIGHT, 128, max rows per stage
- ACC_WIDTH, 28, partial-sum width (20-bit input plus up to 255 channels)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that begins a layer; ignored while busy
- num_channels  in  8  input-channel passes per layer; 0 is treated as 1
- stage_width  in  8  active columns (1..IMAGE_WIDTH)
- stage_height  in  8  active rows (1..IMAGE_HEIGHT); width*height >= 2
- shift  in  5  right-shift applied to the final sum
- pixel_in  in  20  unsigned convolution result
- pixel_valid  in  1  pixel_in valid
- pixel_ready  out  1  block accepts pixel_in this cycle
- pixel_out  out  8  requantised pixel
- out_valid  out  1  pixel_out valid
- out_ready  in  1  downstream accepts pixel_out
- busy  out  1  layer in progress
- done  out  1  one-cycle pulse when the layer is finished

Behaviour:
- Configuration inputs are sampled on the start edge and held internally for the whole layer.
- Reset values: pixel_ready=0, out_valid=0, pixel_out=0, busy=0, done=0, FSM=IDLE. Counters and output FIFO are cleared. Buffer contents are not cleared (pass 0 overwrites them).
- Reset mid-layer aborts immediately. No done pulse. Next start begins a fresh layer.
- FSM states: IDLE, ACCUM, FINAL, DRAIN.
  - IDLE to ACCUM on start when num_channels>1; IDLE to FINAL on start otherwise.
  - ACCUM to FINAL after the last pixel of pass num_channels-2 is accepted.
  - FINAL to DRAIN after the last pixel of the last pass is accepted.
  - DRAIN to IDLE when the FIFO is empty and no write is in flight; done pulses in that cycle.
- busy is high in every state except IDLE.
- Transfer rule: a transfer occurs when pixel_valid && pixel_ready at the edge. Pixels arrive in raster order.
- Position counters: col wraps at stage_width-1 and increments row. At the last row and column, col, row and address return to 0 and pass increments.
- Address: addr = row*stage_width + col.
- Pipeline, two stages, one pixel per cycle sustained:
  - Edge E0 (accept): buffer read of addr is issued; pixel and control are registered.
  - Edge E1: sum = (pass==0 ? 0 : mem[addr]) + pixel. In ACCUM, sum is written back to addr. In FINAL, it is requantised and pushed into the output FIFO.
- No read-after-write hazard: consecutive accepts within a pass hit different addresses (width*height >= 2 guarantees this).
- Requantisation:
  - r = (sum + (shift>0 ? 1<<(shift-1) : 0)) >> shift, computed at ACC_WIDTH+1 bits.
  - pixel_out = (r > 255) ? 255 : r[7:0].
- Output FIFO: depth 2, registered outputs. out_valid = FIFO non-empty. pixel_out = FIFO head.
  - Head pops on out_valid && out_ready.
  - Head data holds stable while out_valid && !out_ready.
- pixel_ready:
  - 1 in ACCUM.
  - In FINAL: 1 only when FIFO occupancy plus in-flight writes is < 2, counting a pop in the same cycle.
  - 0 in IDLE and DRAIN.
- Latency in FINAL: a pixel accepted at edge E0 is visible on out_valid/pixel_out after edge E1, provided the FIFO was empty.
- Simultaneous push and pop on one edge leave occupancy unchanged.
- Sum widths: ACC_WIDTH=28 cannot overflow for 255 channels of 20-bit input. No wrap.

Test Plan:
- 4x4 stage, num_channels=1, shift=0, pixel_in=0..15, out_ready=1 -> outputs 0..15 in order. First out_valid comes 2 edges after the first accept. done pulses once after the 16th output.
- 2x2, num_channels=3, shift=2, each pass pixel_in=10 -> pixel_ready stays 1 throughout. Four outputs of (30+2)>>2 = 8.
- 2x2, num_channels=2, shift=0, pixel_in=200 -> four outputs saturated to 255. shift=4 with input 1000 (sum 2000) -> (2000+8)>>4 = 125.
- FINAL with out_ready held 0 -> exactly 2 pixels accepted, then pixel_ready=0 and pixel_out stays stable. Release out_ready -> data resumes with no loss or duplication.
- Assert rst in pass 1 of 3 -> all outputs at reset values immediately and no done pulse. A new start with num_channels=1 on a 2x1 stage gives correct outputs.
- start pulsed while busy -> ignored and the layer completes unchanged. num_channels=0 behaves exactly as 1.
